// File: rtl/audio_tx_fifo.sv
// audio_tx_fifo: stereo frame FIFO feeding an I2S serialiser, advancing one slot per tx_done.
module audio_tx_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 16
) (
    input  logic                       aud_bclk,
    input  logic                       rst_n,
    input  logic                       aud_lrc,
    input  logic                       tx_done,
    output logic [31:0]                dac_data,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_left,
    input  logic [DW-1:0]              wr_right,
    output logic                       wr_full,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    input  logic                       mute,
    input  logic                       clear,
    output logic                       overflow,
    output logic                       underrun,
    output logic [15:0]                underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic [2*DW-1:0] frame;
    logic [DW-1:0]   sel_sample;
    logic            chan_sel, push, pop, pop_ok;
    assign push       = wr_en && !wr_full;
    assign pop        = tx_done && aud_lrc;
    assign pop_ok     = pop && (count != '0);
    assign fill_level = count;
    assign sel_sample = chan_sel ? frame[DW-1:0] : frame[2*DW-1:DW];
    always_comb count_nxt = count + CW'(push) - CW'(pop_ok);
    always_ff @(posedge aud_bclk)
        if (push && !clear) mem[wr_ptr] <= {wr_left, wr_right};
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wr_full      <= 1'b0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            frame        <= '0;
            chan_sel     <= 1'b0;
            dac_data     <= '0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wr_full      <= 1'b0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            frame        <= '0;
            chan_sel     <= 1'b0;
            dac_data     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            wr_full <= (count_nxt == CW'(DEPTH));
            if (wr_en && wr_full) overflow <= 1'b1;
            if (tx_done) chan_sel <= !aud_lrc;
            // an empty pop loads silence so the serialiser keeps a defined word
            if (pop) frame <= pop_ok ? mem[rd_ptr] : '0;
            if (pop && !pop_ok) begin
                underrun <= 1'b1;
                if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            end
            dac_data <= mute ? 32'd0 : (32'(sel_sample) << (32 - DW));
        end
    end
endmodule

// File: tb/tb_audio_tx_fifo.sv
// tb_audio_tx_fifo: directed checks of audio_tx_fifo (DW=24, DEPTH=16).
module tb_audio_tx_fifo;
    logic        aud_bclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aud_lrc = 1'b0, tx_done = 1'b0, wr_en = 1'b0, mute = 1'b0, clear = 1'b0;
    logic [23:0] wr_left = '0, wr_right = '0;
    logic [31:0] dac_data;
    logic        wr_full, overflow, underrun;
    logic [4:0]  fill_level;
    logic [15:0] underrun_cnt;
    int checks = 0, errors = 0;

    audio_tx_fifo #(.DW(24), .DEPTH(16)) dut (
        .aud_bclk(aud_bclk), .rst_n(rst_n), .aud_lrc(aud_lrc), .tx_done(tx_done),
        .dac_data(dac_data), .wr_en(wr_en), .wr_left(wr_left), .wr_right(wr_right),
        .wr_full(wr_full), .fill_level(fill_level), .mute(mute), .clear(clear),
        .overflow(overflow), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 aud_bclk = ~aud_bclk;

    task automatic tick();
        @(posedge aud_bclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        wr_en = 1'b1; wr_left = l; wr_right = r;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic slot(input logic lrc);
        tx_done = 1'b1; aud_lrc = lrc;
        tick();
        tx_done = 1'b0;
        tick();
    endtask

    initial begin
        tick(); tick();
        chk("rst_dac", dac_data, 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_full", 32'(wr_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udr", 32'(underrun), 0);
        chk("rst_cnt", 32'(underrun_cnt), 0);
        rst_n = 1'b1;
        tick();
        push(24'h123456, 24'hABCDEF);
        push(24'h111111, 24'h222222);
        push(24'h333333, 24'h444444);
        chk("t1_fill3", 32'(fill_level), 3);
        slot(1'b1);
        chk("t1_left", dac_data, 32'h12345600);
        chk("t1_fill2", 32'(fill_level), 2);
        slot(1'b0);
        chk("t1_right", dac_data, 32'hABCDEF00);
        slot(1'b1); chk("t1_l1", dac_data, 32'h11111100);
        slot(1'b0); chk("t1_r1", dac_data, 32'h22222200);
        slot(1'b1); chk("t1_l2", dac_data, 32'h33333300);
        slot(1'b0); chk("t1_r2", dac_data, 32'h44444400);
        chk("t1_udr_clean", 32'(underrun), 0);
        slot(1'b1);
        chk("t2_dac", dac_data, 0);
        chk("t2_udr", 32'(underrun), 1);
        chk("t2_cnt1", 32'(underrun_cnt), 1);
        slot(1'b1); slot(1'b1); slot(1'b1);
        chk("t2_cnt4", 32'(underrun_cnt), 4);
        chk("t2_fill0", 32'(fill_level), 0);
        for (int i = 0; i < 17; i++) push(24'h100000 + 24'(i), 24'h200000 + 24'(i));
        chk("t3_full", 32'(wr_full), 1);
        chk("t3_fill", 32'(fill_level), 16);
        chk("t3_ovf", 32'(overflow), 1);
        for (int i = 0; i < 16; i++) begin
            slot(1'b1);
            chk($sformatf("t3_drain_l%0d", i), dac_data, 32'h10000000 + 32'(i << 8));
            slot(1'b0);
        end
        slot(1'b1);
        chk("t3_extra_dropped", dac_data, 0);
        chk("t3_cnt5", 32'(underrun_cnt), 5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("clr_fill", 32'(fill_level), 0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_udr", 32'(underrun), 0);
        chk("clr_cnt", 32'(underrun_cnt), 0);
        for (int i = 0; i < 16; i++) push(24'h100000 + 24'(i), 24'h200000 + 24'(i));
        chk("t4_full", 32'(wr_full), 1);
        chk("t4_ovf_pre", 32'(overflow), 0);
        wr_en = 1'b1; wr_left = 24'hEEEEEE; wr_right = 24'hEEEEEE;
        tx_done = 1'b1; aud_lrc = 1'b1;
        tick();
        wr_en = 1'b0; tx_done = 1'b0;
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_fill", 32'(fill_level), 15);
        chk("t4_notfull", 32'(wr_full), 0);
        tick();
        chk("t4_l0", dac_data, 32'h10000000);
        slot(1'b0);
        chk("t4_r0", dac_data, 32'h20000000);
        mute = 1'b1;
        slot(1'b1); chk("t5_mute_a", dac_data, 0);
        slot(1'b0); chk("t5_mute_b", dac_data, 0);
        slot(1'b1); chk("t5_mute_c", dac_data, 0);
        slot(1'b0); chk("t5_mute_d", dac_data, 0);
        chk("t5_fill", 32'(fill_level), 13);
        mute = 1'b0;
        slot(1'b1); chk("t5_l3", dac_data, 32'h10000300);
        slot(1'b0); chk("t5_r3", dac_data, 32'h20000300);
        for (int i = 0; i < 7; i++) slot(1'b1);
        chk("t6_fill5", 32'(fill_level), 5);
        chk("t6_dac_pre", dac_data, 32'h10000A00);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("t6_fill", 32'(fill_level), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_dac", dac_data, 0);
        chk("t6_cnt", 32'(underrun_cnt), 0);
        push(24'hAAAAAA, 24'h555555);
        push(24'hAAAAAA, 24'h555555);
        slot(1'b1);
        chk("t6_dac_live", dac_data, 32'hAAAAAA00);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_arst_dac", dac_data, 0);
        chk("t6_arst_fill", 32'(fill_level), 0);
        #20 rst_n = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
